// File: rtl/pc_sequencer.sv
// Next-PC selection and stall/flush sequencing for the fetch-side PC register.
// Optional macro PC_DELAY_SLOT_EN: branches execute one delay slot before redirecting.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    input  logic        load_use,
    input  logic        div_start,
    output logic [31:0] next_pc,
    output logic        pc_wena,
    output logic        stall,
    output logic        if_flush,
    output logic        div_busy,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_DIV = 2'd1;
    localparam logic [1:0] ST_EXC = 2'd2;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pv_q, pv_d;
    logic [31:0] pt_q, pt_d;
    logic        busy_q;
    logic [31:0] seq_pc;
    logic        br_latch;

    assign seq_pc = pc_cur + 32'd4;

    // With delay slots an outstanding target must not be overwritten.
`ifdef PC_DELAY_SLOT_EN
    assign br_latch = br_req && !pv_q;
`else
    assign br_latch = br_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pv_d     = pv_q;
        pt_d     = pt_q;
        next_pc  = seq_pc;
        pc_wena  = 1'b0;
        stall    = 1'b0;
        if_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    next_pc  = EXC_VECTOR;
                    pc_wena  = 1'b1;
                    if_flush = 1'b1;
                    pv_d     = 1'b0;
                    state_d  = ST_EXC;
                end else if (eret_req) begin
                    next_pc  = epc_in;
                    pc_wena  = 1'b1;
                    if_flush = 1'b1;
                    pv_d     = 1'b0;
                end else if (div_start) begin
                    stall   = 1'b1;
                    cnt_d   = DIV_LOAD;
                    state_d = ST_DIV;
                    if (br_latch) begin
                        pv_d = 1'b1;
                        pt_d = br_target;
                    end
                end else if (load_use) begin
                    stall = 1'b1;
                    if (br_latch) begin
                        pv_d = 1'b1;
                        pt_d = br_target;
                    end
                end else begin
                    pc_wena = 1'b1;
                    pv_d    = 1'b0;
`ifdef PC_DELAY_SLOT_EN
                    // Delay slot is fetched sequentially; target applies one write later.
                    if (pv_q) begin
                        next_pc = pt_q;
                    end else if (br_req) begin
                        pv_d = 1'b1;
                        pt_d = br_target;
                    end
`else
                    if (br_req) begin
                        next_pc  = br_target;
                        if_flush = 1'b1;
                    end else if (pv_q) begin
                        next_pc  = pt_q;
                        if_flush = 1'b1;
                    end
`endif
                end
            end

            ST_DIV: begin
                if (exc_req) begin
                    next_pc  = EXC_VECTOR;
                    pc_wena  = 1'b1;
                    if_flush = 1'b1;
                    pv_d     = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = ST_EXC;
                end else begin
                    stall = 1'b1;
                    if (br_latch) begin
                        pv_d = 1'b1;
                        pt_d = br_target;
                    end
                    if (cnt_q == 8'd0)
                        state_d = ST_RUN;
                    else
                        cnt_d = cnt_q - 8'd1;
                end
            end

            ST_EXC: begin
                pc_wena  = 1'b1;
                if_flush = 1'b1;
                pv_d     = 1'b0;
                if (exc_req)
                    next_pc = EXC_VECTOR;
                else
                    state_d = ST_RUN;
            end

            default: state_d = ST_RUN;
        endcase

        if (!rst) begin
            next_pc  = RESET_PC;
            pc_wena  = 1'b0;
            stall    = 1'b1;
            if_flush = 1'b1;
            state_d  = ST_RUN;
            cnt_d    = 8'd0;
            pv_d     = 1'b0;
            pt_d     = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pv_q    <= pv_d;
        pt_q    <= pt_d;
        busy_q  <= (state_d == ST_DIV);
    end

    assign div_busy = busy_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (DIV_CYCLES=4).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        br_req;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_in;
    logic        load_use;
    logic        div_start;
    logic [31:0] next_pc;
    logic        pc_wena;
    logic        stall;
    logic        if_flush;
    logic        div_busy;
    logic [1:0]  state_o;

    int n_chk  = 0;
    int n_fail = 0;

    pc_sequencer #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .br_req(br_req), .br_target(br_target),
        .exc_req(exc_req), .eret_req(eret_req), .epc_in(epc_in), .load_use(load_use),
        .div_start(div_start), .next_pc(next_pc), .pc_wena(pc_wena), .stall(stall),
        .if_flush(if_flush), .div_busy(div_busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle inputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pc_cur = 32'h0040_0000; br_req = 0; br_target = 0;
        exc_req = 0; eret_req = 0; epc_in = 0; load_use = 0; div_start = 0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_next_pc", next_pc, 32'h0040_0000);
            chk("rst_stall", stall, 1);
            chk("rst_flush", if_flush, 1);
            chk("rst_wena", pc_wena, 0);
            chk("rst_busy", div_busy, 0);
            chk("rst_state", state_o, 0);
        end
        rst = 1'b1; #1;
        chk("rel_next_pc", next_pc, 32'h0040_0004);
        chk("rel_wena", pc_wena, 1);
        chk("rel_stall", stall, 0);
        chk("rel_flush", if_flush, 0);

        // Divide with concurrent branch
        pc_cur = 32'h0040_0004; div_start = 1; br_req = 1; br_target = 32'h0040_0100; #1;
        chk("div_start_stall", stall, 1);
        chk("div_start_wena", pc_wena, 0);
        tick();
        div_start = 0; br_req = 0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("div_busy", div_busy, 1);
            chk("div_stall", stall, 1);
            chk("div_wena", pc_wena, 0);
            chk("div_state", state_o, 1);
            tick();
        end
        chk("div_done_busy", div_busy, 0);
        chk("div_done_state", state_o, 0);
        chk("div_done_next_pc", next_pc, 32'h0040_0100);
        chk("div_done_flush", if_flush, 1);
        chk("div_done_wena", pc_wena, 1);
        tick();
        chk("div_pend_clr", next_pc, 32'h0040_0008);
        chk("div_pend_flush", if_flush, 0);

        // Exception aborts a running divide and drops its pending branch
        div_start = 1; br_req = 1; br_target = 32'h0040_0300;
        tick();
        div_start = 0; br_req = 0;
        tick(); tick();
        exc_req = 1; #1;
        chk("abort_next_pc", next_pc, 32'h0040_0004);
        chk("abort_flush", if_flush, 1);
        chk("abort_wena", pc_wena, 1);
        chk("abort_stall", stall, 0);
        tick();
        exc_req = 0; #1;
        chk("exf_state", state_o, 2);
        chk("exf_flush", if_flush, 1);
        chk("exf_busy", div_busy, 0);
        chk("exf_next_pc", next_pc, 32'h0040_0008);
        tick();
        chk("post_exc_state", state_o, 0);
        chk("post_exc_next_pc", next_pc, 32'h0040_0008);
        chk("post_exc_flush", if_flush, 0);

        // Load-use with changing branch targets; newest wins
        load_use = 1; br_req = 1; br_target = 32'h0040_0040; #1;
        chk("lu1_stall", stall, 1);
        chk("lu1_wena", pc_wena, 0);
        tick();
        br_target = 32'h0040_0080; #1;
        chk("lu2_stall", stall, 1);
        tick();
        load_use = 0; br_req = 0; #1;
        chk("lu_rel_next_pc", next_pc, 32'h0040_0080);
        chk("lu_rel_flush", if_flush, 1);
        chk("lu_rel_stall", stall, 0);
        tick();

        // Wraparound and priority
        pc_cur = 32'hFFFF_FFFC; #1;
        chk("wrap_next_pc", next_pc, 32'h0000_0000);
        chk("wrap_flush", if_flush, 0);
        exc_req = 1; eret_req = 1; load_use = 1; epc_in = 32'h0040_0500; #1;
        chk("prio_next_pc", next_pc, 32'h0040_0004);
        chk("prio_stall", stall, 0);
        chk("prio_wena", pc_wena, 1);
        tick();
        exc_req = 0; eret_req = 0; load_use = 0; #1;
        chk("prio_state", state_o, 2);
        tick();

        // ERET
        pc_cur = 32'h0040_0010; eret_req = 1; #1;
        chk("eret_next_pc", next_pc, 32'h0040_0500);
        chk("eret_flush", if_flush, 1);
        tick();
        eret_req = 0; #1;
        chk("eret_state", state_o, 0);

        // Branch in an unstalled cycle
        br_req = 1; br_target = 32'h0040_0200; #1;
`ifdef PC_DELAY_SLOT_EN
        chk("ds_slot_next_pc", next_pc, 32'h0040_0014);
        chk("ds_slot_flush", if_flush, 0);
        tick();
        br_req = 0; #1;
        chk("ds_tgt_next_pc", next_pc, 32'h0040_0200);
        chk("ds_tgt_flush", if_flush, 0);
`else
        chk("br_next_pc", next_pc, 32'h0040_0200);
        chk("br_flush", if_flush, 1);
        tick();
        br_req = 0; #1;
        chk("br_after_next_pc", next_pc, 32'h0040_0014);
        chk("br_after_flush", if_flush, 0);
`endif
        tick();

        // Reset mid-divide
        div_start = 1;
        tick();
        div_start = 0; #1;
        chk("mid_busy", div_busy, 1);
        rst = 0; #1;
        chk("mid_rst_next_pc", next_pc, 32'h0040_0000);
        chk("mid_rst_stall", stall, 1);
        tick();
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_busy", div_busy, 0);
        rst = 1; #1;
        chk("mid_rel_next_pc", next_pc, 32'h0040_0014);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the fetch-side program counter register in the dynamic pipeline.
- Each cycle it picks the next PC from these sources: sequential, branch/jump, exception vector, or ERET return.
- It drives the PC register's write enable, stall and flush inputs.
- It sequences load-use and multi-cycle-divide stalls.
- It holds a branch redirect that arrives during a stall until fetch resumes.
- It sits between the ID/EX hazard and redirect logic and the PC register / IF stage.

Parameters:
RESET_PC, 32'h00400000, next_pc value driven while in reset (MIPS text base)
EXC_VECTOR, 32'h00400004, exception entry address
DIV_CYCLES, 32, number of stall cycles per divide (legal range 2..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-low
pc_cur  input  32  current PC from the PC register
br_req  input  1  taken branch/jump request from ID
br_target  input  32  branch/jump target
exc_req  input  1  exception request from EX
eret_req  input  1  exception-return request
epc_in  input  32  return address used for ERET
load_use  input  1  load-use hazard (level)
div_start  input  1  divide issued in EX (pulse)
next_pc  output  32  next PC to the PC register's data input
pc_wena  output  1  PC register write enable
stall  output  1  pipeline stall (PC hold, IF/ID hold)
if_flush  output  1  kill the instruction in IF/ID
div_busy  output  1  registered; high while the divide counter runs
state_o  output  2  current state, for debug

Behaviour:
Encoding and output timing
- States: RUN=0, DIV_WAIT=1, EXC_FLUSH=2.
- Registers: state, div_cnt[7:0], pend_valid, pend_target[31:0].
- All outputs except div_busy are combinational from state, registers and inputs.
- A redirect takes effect at the next rising clk edge.

Arithmetic
- seq_pc = pc_cur + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.

Reset
- While rst=0 at a clock edge, the next state is RUN, div_cnt=0, pend_valid=0, pend_target=0.
- While rst=0, outputs are: next_pc=RESET_PC, pc_wena=0, stall=1, if_flush=1, div_busy=0 (held from the first reset edge).
- Reset asserted mid-divide or mid-flush aborts that operation at the same edge.

RUN priority (highest first):
1. exc_req:
   - next_pc=EXC_VECTOR, pc_wena=1, if_flush=1, stall=0.
   - Clear pend_valid; go to EXC_FLUSH.
2. eret_req:
   - next_pc=epc_in, pc_wena=1, if_flush=1.
   - Clear pend_valid; stay in RUN.
3. div_start:
   - stall=1, pc_wena=0.
   - Load div_cnt=DIV_CYCLES-1; go to DIV_WAIT.
   - If br_req is also high, set pend_valid=1 and pend_target=br_target.
4. load_use:
   - stall=1, pc_wena=0; stay in RUN.
   - If br_req is high, latch the pending branch (newest br_target overwrites).
5. Unstalled cycle:
   - pc_wena=1.
   - If br_req: next_pc=br_target, if_flush=1.
   - Else if pend_valid: next_pc=pend_target, if_flush=1.
   - Else: next_pc=seq_pc, if_flush=0.
   - Clear pend_valid.

DIV_WAIT
- stall=1, pc_wena=0, div_busy=1; div_cnt decrements each cycle.
- br_req latches the pending branch (overwrite). load_use is ignored.
- When div_cnt==0, go to RUN on that edge. Stall is therefore exactly DIV_CYCLES cycles counted from div_start.
- exc_req aborts the divide: same outputs as RUN rule 1, div_cnt=0, go to EXC_FLUSH.
- eret_req and div_start are ignored.

EXC_FLUSH (one cycle)
- if_flush=1, pc_wena=1, next_pc=seq_pc; clear pend_valid.
- br_req, load_use, div_start and eret_req are ignored.
- A new exc_req re-applies RUN rule 1 and stays in EXC_FLUSH; otherwise go to RUN.

Invariants
- pc_wena and stall are never both 1.
- div_busy=1 exactly when state==DIV_WAIT.

Optional Feature:
- Macro: PC_DELAY_SLOT_EN.
- When defined:
  - A br_req in an unstalled RUN cycle writes seq_pc (the delay slot is fetched) with if_flush=0, and latches pend_target=br_target.
  - The pending target is applied on the next unstalled cycle with if_flush=0.
  - A br_req arriving while pend_valid=1 is ignored.
  - Exception and ERET behaviour is unchanged and clears pend_valid.
- When undefined: branches redirect immediately with if_flush=1, as specified above.

Test Plan:
1. Hold rst=0 for 3 cycles, then release with pc_cur=32'h00400000 and no requests → during reset next_pc=32'h00400000, stall=1, if_flush=1, pc_wena=0; after release next_pc=32'h00400004, pc_wena=1.
2. DIV_CYCLES=4; div_start pulse plus br_req (target 32'h00400100) in the same cycle → stall=1 and div_busy=1 for exactly 4 cycles; next cycle next_pc=32'h00400100, if_flush=1, pc_wena=1.
3. Divide running with 2 cycles left, then exc_req → that cycle next_pc=32'h00400004, if_flush=1; next cycle EXC_FLUSH with if_flush=1; pending branch dropped; div_busy=0.
4. load_use held 2 cycles while br_req toggles targets 32'h00400040 then 32'h00400080 → stall=1 for both cycles; on release with br_req low, next_pc=32'h00400080.
5. pc_cur=32'hFFFFFFFC, no requests → next_pc=32'h00000000. Same cycle exc_req+eret_req+load_use → exception wins: next_pc=EXC_VECTOR, stall=0.
6. With PC_DELAY_SLOT_EN: br_req target 32'h00400200 at pc_cur=32'h00400010 → next_pc=32'h00400014, if_flush=0; next cycle next_pc=32'h00400200, if_flush=0.
